// File: rtl/prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// prog_sequencer_if
//
// Purpose:
//   Bundles the control and status signals exchanged between the program
//   sequencer and its environment (controller, processor core, exception
//   monitor). Clock and reset are not part of the bundle; they stay plain
//   ports on the sequencer.
//
// Signals:
//   Start      launch request, sampled only while the sequencer is idle
//   ProgSel    program number 1..3 (0 is invalid)
//   Halt       core has executed its halt instruction
//   ProgState  running program number, 0 when no program is active
//   PCInit     one-cycle strobe telling the core to load its PC
//   StartAddr  start address of the latched program
//   Busy       high while a program is being loaded or is running
//   Done       one-cycle completion pulse
//   Timeout    last run was stopped by the cycle limit
//   CycleCount RUN cycles of the current or last program
//
// Modports:
//   master  the environment side: drives the requests, observes status
//   slave   the sequencer side: observes the requests, drives status
// ---------------------------------------------------------------------------
interface prog_sequencer_if;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Halt;
  logic [1:0]  ProgState;
  logic        PCInit;
  logic [9:0]  StartAddr;
  logic        Busy;
  logic        Done;
  logic        Timeout;
  logic [15:0] CycleCount;

  modport master (
    output Start,
    output ProgSel,
    output Halt,
    input  ProgState,
    input  PCInit,
    input  StartAddr,
    input  Busy,
    input  Done,
    input  Timeout,
    input  CycleCount
  );

  modport slave (
    input  Start,
    input  ProgSel,
    input  Halt,
    output ProgState,
    output PCInit,
    output StartAddr,
    output Busy,
    output Done,
    output Timeout,
    output CycleCount
  );
endinterface

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//
// Purpose:
//   Launches one of three stored programs on a processor core and supervises
//   it. A launch request selects the program, the sequencer strobes the core
//   to load its PC from the program's start address, counts the cycles the
//   program runs, and ends the run either when the core reports a halt or
//   when the cycle limit is reached. A completion pulse marks every run that
//   ends normally or by timeout; a reset aborts a run silently.
//
//   State flow: IDLE -> LOAD (1 cycle) -> RUN (until halt/timeout)
//               -> DONE (1 cycle) -> IDLE
//
// Parameters:
//   START_ADDR1..3  PC start addresses of programs 1..3
//   TIMEOUT         maximum number of RUN cycles before a forced stop
//
// Ports:
//   CLK     single clock, all state changes on its rising edge
//   ResetN  asynchronous, active-low reset
//   bus     prog_sequencer_if slave modport (requests in, status out)
//
// All outputs come straight from flops so they are glitch-free; each flop
// is loaded with the value that belongs to the state being entered.
// ---------------------------------------------------------------------------
module prog_sequencer #(
  parameter logic [9:0]  START_ADDR1 = 10'd0,
  parameter logic [9:0]  START_ADDR2 = 10'd128,
  parameter logic [9:0]  START_ADDR3 = 10'd256,
  parameter logic [15:0] TIMEOUT     = 16'd4000
) (
  input  logic             CLK,
  input  logic             ResetN,
  prog_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // The timeout fires on the RUN cycle whose incoming count is TIMEOUT-1,
  // so the run lasts exactly TIMEOUT cycles and ends with CycleCount equal
  // to TIMEOUT. A TIMEOUT of 0 wraps to 16'hFFFF, i.e. the longest run.
  localparam logic [15:0] LAST_RUN_COUNT = TIMEOUT - 16'd1;
  localparam logic [15:0] COUNT_MAX      = 16'hFFFF;

  state_e      state_q,       state_d;
  logic [1:0]  sel_q,         sel_d;
  logic [1:0]  prog_state_q,  prog_state_d;
  logic        pc_init_q,     pc_init_d;
  logic [9:0]  start_addr_q,  start_addr_d;
  logic        busy_q,        busy_d;
  logic        done_q,        done_d;
  logic        timeout_q,     timeout_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  function automatic logic [9:0] addr_for(input logic [1:0] sel);
    logic [9:0] addr;
    case (sel)
      2'd1:    addr = START_ADDR1;
      2'd2:    addr = START_ADDR2;
      2'd3:    addr = START_ADDR3;
      default: addr = 10'd0;
    endcase
    return addr;
  endfunction

  // Next-state and next-output decode. Strobes (PCInit, Done) default low
  // and are raised only on the transition into their one-cycle state;
  // everything else holds unless a transition changes it. Start is looked
  // at only in IDLE and Halt only in RUN, so neither can be queued.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    prog_state_d  = prog_state_q;
    pc_init_d     = 1'b0;
    start_addr_d  = start_addr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      IDLE: begin
        if (bus.Start && (bus.ProgSel != 2'd0)) begin
          state_d       = LOAD;
          sel_d         = bus.ProgSel;
          prog_state_d  = bus.ProgSel;
          start_addr_d  = addr_for(bus.ProgSel);
          pc_init_d     = 1'b1;
          busy_d        = 1'b1;
          cycle_count_d = 16'd0;
          timeout_d     = 1'b0;
        end
      end

      LOAD: begin
        state_d = RUN;
      end

      RUN: begin
        // Every RUN cycle counts, including the one that ends the run.
        if (cycle_count_q != COUNT_MAX) begin
          cycle_count_d = cycle_count_q + 16'd1;
        end
        // Halt is checked first so it wins over a simultaneous timeout.
        if (bus.Halt) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cycle_count_q == LAST_RUN_COUNT) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end

      DONE: begin
        state_d      = IDLE;
        prog_state_d = 2'd0;
      end

      default: begin
        state_d      = IDLE;
        prog_state_d = 2'd0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset clears everything at once,
  // independent of the clock, so a run in progress is dropped with no
  // completion pulse.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= IDLE;
      sel_q         <= 2'd0;
      prog_state_q  <= 2'd0;
      pc_init_q     <= 1'b0;
      start_addr_q  <= 10'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      prog_state_q  <= prog_state_d;
      pc_init_q     <= pc_init_d;
      start_addr_q  <= start_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.ProgState  = prog_state_q;
  assign bus.PCInit     = pc_init_q;
  assign bus.StartAddr  = start_addr_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.Timeout    = timeout_q;
  assign bus.CycleCount = cycle_count_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
//
// Purpose:
//   Drives two sequencers with identical stimulus: one with the default
//   parameters (TIMEOUT=4000) and one with TIMEOUT=8. A cycle-level model of
//   the launch/run/complete rules predicts all outputs of both every cycle,
//   and directed literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic       halt = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_sequencer_if if_a ();
  prog_sequencer_if if_b ();

  assign if_a.Start   = start;
  assign if_a.ProgSel = prog_sel;
  assign if_a.Halt    = halt;
  assign if_b.Start   = start;
  assign if_b.ProgSel = prog_sel;
  assign if_b.Halt    = halt;

  prog_sequencer dut_a (
    .CLK    (clk),
    .ResetN (rst_n),
    .bus    (if_a)
  );

  prog_sequencer #(
    .TIMEOUT (16'd8)
  ) dut_b (
    .CLK    (clk),
    .ResetN (rst_n),
    .bus    (if_b)
  );

  // Packed view of every output: ProgState, PCInit, StartAddr, Busy, Done,
  // Timeout, CycleCount.
  logic [31:0] out_a;
  logic [31:0] out_b;
  assign out_a = {if_a.ProgState, if_a.PCInit, if_a.StartAddr, if_a.Busy,
                  if_a.Done, if_a.Timeout, if_a.CycleCount};
  assign out_b = {if_b.ProgState, if_b.PCInit, if_b.StartAddr, if_b.Busy,
                  if_b.Done, if_b.Timeout, if_b.CycleCount};

  // Behavioural model: phase 0 idle, 1 loading, 2 running, 3 finished.
  typedef struct {
    int phase;
    int sel;
    int runs;
    bit tmo;
  } model_t;

  model_t m_a;
  model_t m_b;

  function automatic model_t model_reset();
    model_t r;
    r.phase = 0;
    r.sel   = 0;
    r.runs  = 0;
    r.tmo   = 1'b0;
    return r;
  endfunction

  function automatic int addr_of(input int sel);
    if (sel == 1) return 0;
    if (sel == 2) return 128;
    if (sel == 3) return 256;
    return 0;
  endfunction

  function automatic model_t model_step(input model_t m, input logic st,
                                        input logic [1:0] ps, input logic hl,
                                        input int limit);
    model_t n;
    int last;
    n = m;
    last = (limit + 65535) % 65536;
    case (m.phase)
      0: begin
        if (st && ps != 2'd0) begin
          n.phase = 1;
          n.sel   = int'(ps);
          n.runs  = 0;
          n.tmo   = 1'b0;
        end
      end
      1: n.phase = 2;
      2: begin
        n.runs = (m.runs < 65535) ? m.runs + 1 : 65535;
        if (hl) begin
          n.phase = 3;
        end else if (m.runs == last) begin
          n.phase = 3;
          n.tmo   = 1'b1;
        end
      end
      default: n.phase = 0;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] model_out(input model_t m);
    logic [1:0]  ps;
    logic        pci;
    logic [9:0]  addr;
    logic        bsy;
    logic        dn;
    logic [15:0] cnt;
    ps   = (m.phase == 0) ? 2'd0 : m.sel[1:0];
    pci  = (m.phase == 1);
    addr = 10'(addr_of(m.sel));
    bsy  = (m.phase == 1) || (m.phase == 2);
    dn   = (m.phase == 3);
    cnt  = m.runs[15:0];
    return {ps, pci, addr, bsy, dn, m.tmo, cnt};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= model_reset();
      m_b <= model_reset();
    end else begin
      m_a <= model_step(m_a, start, prog_sel, halt, 4000);
      m_b <= model_step(m_b, start, prog_sel, halt, 8);
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    checks = checks + 1;
    if (out_a !== model_out(m_a)) begin
      failures = failures + 1;
      $display("[TB] FAIL cycle_a at %0t: got %h expected %h", $time, out_a, model_out(m_a));
    end
    checks = checks + 1;
    if (out_b !== model_out(m_b)) begin
      failures = failures + 1;
      $display("[TB] FAIL cycle_b at %0t: got %h expected %h", $time, out_b, model_out(m_b));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] ps, input logic hl);
    start    = st;
    prog_sel = ps;
    halt     = hl;
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_a_outputs", out_a, 32'd0);
    checkOutput("reset_b_outputs", out_b, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step_cycles(1);

    // Start with ProgSel=0 is ignored
    applyStimulus(1'b1, 2'd0, 1'b0);
    step_cycles(2);
    checkOutput("sel0_progstate", 32'(if_a.ProgState), 32'd0);
    checkOutput("sel0_pcinit", 32'(if_a.PCInit), 32'd0);

    // Launch program 2, halt in the 10th RUN cycle
    applyStimulus(1'b1, 2'd2, 1'b0);
    step_cycles(1);
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("load_pcinit", 32'(if_a.PCInit), 32'd1);
    checkOutput("load_startaddr", 32'(if_a.StartAddr), 32'd128);
    checkOutput("load_progstate", 32'(if_a.ProgState), 32'd2);
    checkOutput("load_busy", 32'(if_a.Busy), 32'd1);
    step_cycles(1);
    checkOutput("run_pcinit_low", 32'(if_a.PCInit), 32'd0);
    step_cycles(2);
    applyStimulus(1'b1, 2'd1, 1'b0);
    step_cycles(2);
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("start_in_run_pcinit", 32'(if_a.PCInit), 32'd0);
    checkOutput("start_in_run_progstate", 32'(if_a.ProgState), 32'd2);
    step_cycles(5);
    applyStimulus(1'b0, 2'd0, 1'b1);
    step_cycles(1);
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("halt_done", 32'(if_a.Done), 32'd1);
    checkOutput("halt_count", 32'(if_a.CycleCount), 32'd10);
    checkOutput("halt_timeout", 32'(if_a.Timeout), 32'd0);
    checkOutput("b_timeout_flag", 32'(if_b.Timeout), 32'd1);
    checkOutput("b_timeout_count", 32'(if_b.CycleCount), 32'd8);
    checkOutput("b_idle_progstate", 32'(if_b.ProgState), 32'd0);
    step_cycles(1);
    checkOutput("after_done_progstate", 32'(if_a.ProgState), 32'd0);
    checkOutput("after_done_count_held", 32'(if_a.CycleCount), 32'd10);

    // Start held high; halt on the exact timeout cycle of dut_b
    applyStimulus(1'b1, 2'd1, 1'b0);
    step_cycles(1);
    checkOutput("p1_load_pcinit", 32'(if_b.PCInit), 32'd1);
    checkOutput("p1_load_addr", 32'(if_b.StartAddr), 32'd0);
    step_cycles(8);
    applyStimulus(1'b1, 2'd1, 1'b1);
    step_cycles(1);
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("tie_done", 32'(if_b.Done), 32'd1);
    checkOutput("tie_timeout", 32'(if_b.Timeout), 32'd0);
    checkOutput("tie_count", 32'(if_b.CycleCount), 32'd8);
    step_cycles(1);
    checkOutput("held_start_idle_pcinit", 32'(if_b.PCInit), 32'd0);
    checkOutput("held_start_idle_progstate", 32'(if_b.ProgState), 32'd0);
    step_cycles(1);
    checkOutput("held_start_relaunch_b", 32'(if_b.PCInit), 32'd1);
    checkOutput("held_start_relaunch_a", 32'(if_a.PCInit), 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b0);

    // Timeout on dut_b holds through IDLE and is cleared by the next LOAD
    step_cycles(9);
    checkOutput("to_done", 32'(if_b.Done), 32'd1);
    checkOutput("to_flag", 32'(if_b.Timeout), 32'd1);
    checkOutput("to_count", 32'(if_b.CycleCount), 32'd8);
    step_cycles(3);
    checkOutput("to_flag_held", 32'(if_b.Timeout), 32'd1);
    applyStimulus(1'b1, 2'd3, 1'b0);
    step_cycles(1);
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("reload_timeout_clear", 32'(if_b.Timeout), 32'd0);
    checkOutput("reload_count_clear", 32'(if_b.CycleCount), 32'd0);
    checkOutput("reload_addr", 32'(if_b.StartAddr), 32'd256);
    step_cycles(3);

    // Asynchronous reset mid-RUN
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_a", out_a, 32'd0);
    checkOutput("async_reset_b", out_b, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // First Start after reset is accepted at the first edge
    applyStimulus(1'b1, 2'd3, 1'b0);
    step_cycles(1);
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("post_reset_pcinit", 32'(if_a.PCInit), 32'd1);
    checkOutput("post_reset_addr", 32'(if_a.StartAddr), 32'd256);
    checkOutput("post_reset_progstate", 32'(if_a.ProgState), 32'd3);

    // Default TIMEOUT on dut_a, bounded wait for its Done pulse
    found = 1'b0;
    for (int i = 0; i < 4100; i++) begin
      step_cycles(1);
      if (if_a.Done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("default_timeout_seen", 32'(found), 32'd1);
    checkOutput("default_timeout_count", 32'(if_a.CycleCount), 32'd4000);
    checkOutput("default_timeout_flag", 32'(if_a.Timeout), 32'd1);
    step_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
